// File: rtl/alu.sv
// 32-bit sequential ALU: two-word operand capture, single-cycle ops,
// iterative Booth multiply and non-restoring divide returning two words.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] ibus,
  output logic [WIDTH-1:0] obus,
  output logic             fin
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = WIDTH + 2;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SHR = 4'b0101,
    OP_SHL = 4'b0110,
    OP_AND = 4'b0111,
    OP_OR  = 4'b1000,
    OP_NEG = 4'b1001,
    OP_MUL = 4'b1010,
    OP_DIV = 4'b1011
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_ITER,
    S_OUT1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_q;
  logic [AW-1:0]    r_acc;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;

  logic             w_op_valid;
  logic             w_is_iter;
  logic             w_last;
  logic [WIDTH-1:0] w_exec;
  logic             w_x_neg;
  logic             w_y_neg;
  logic [WIDTH-1:0] w_x_mag;
  logic [WIDTH-1:0] w_y_mag;
  logic [AW-1:0]    w_m;
  logic [AW-1:0]    w_d;
  logic [AW-1:0]    w_booth_sum;
  logic [AW-1:0]    w_div_sh;
  logic [AW-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_op_valid = opcode inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND,
                                     OP_OR, OP_NEG, OP_MUL, OP_DIV};
  assign w_is_iter  = (r_op == OP_MUL) || (r_op == OP_DIV);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_x_neg    = r_x[WIDTH-1];
  assign w_y_neg    = r_y[WIDTH-1];
  assign w_x_mag    = w_x_neg ? -r_x : r_x;
  assign w_y_mag    = w_y_neg ? -r_y : r_y;

  // State register
  always_ff @(posedge clk) begin
    if (rst_b) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state sequencing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_op_valid) w_state_nxt = S_LOAD_Y;
      S_LOAD_Y: w_state_nxt = w_is_iter ? S_ITER : S_EXEC;
      S_EXEC:   w_state_nxt = S_IDLE;
      S_ITER:   if (w_last) w_state_nxt = S_OUT1;
      S_OUT1:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle result selection
  always_comb begin
    w_exec = '0;
    case (r_op)
      OP_ADD:  w_exec = r_x + r_y;
      OP_SUB:  w_exec = r_x - r_y;
      OP_SHR:  w_exec = $signed(r_x) >>> r_y[CW-1:0];
      OP_SHL:  w_exec = r_x << r_y[CW-1:0];
      OP_AND:  w_exec = r_x & r_y;
      OP_OR:   w_exec = r_x | r_y;
      OP_NEG:  w_exec = -r_x;
      default: w_exec = '0;
    endcase
  end

  // One Booth step or one non-restoring divide step, plus final divide correction
  always_comb begin
    w_m         = {{2{r_y[WIDTH-1]}}, r_y};
    w_d         = {2'b00, w_y_mag};
    w_booth_sum = r_acc;
    w_div_sh    = {r_acc[AW-2:0], r_q[WIDTH-1]};
    w_acc_nxt   = r_acc;
    w_q_nxt     = r_q;
    if (r_op == OP_MUL) begin
      case ({r_q[0], r_qm1})
        2'b01:   w_booth_sum = r_acc + w_m;
        2'b10:   w_booth_sum = r_acc - w_m;
        default: w_booth_sum = r_acc;
      endcase
      w_acc_nxt = {w_booth_sum[AW-1], w_booth_sum[AW-1:1]};
      w_q_nxt   = {w_booth_sum[0], r_q[WIDTH-1:1]};
    end else begin
      w_acc_nxt = r_acc[AW-1] ? (w_div_sh + w_d) : (w_div_sh - w_d);
      w_q_nxt   = {r_q[WIDTH-2:0], ~w_acc_nxt[AW-1]};
    end
    // Division runs on magnitudes; signs are restored here on the last step
    w_rem_mag = w_acc_nxt[AW-1] ? (w_acc_nxt[WIDTH-1:0] + w_y_mag) : w_acc_nxt[WIDTH-1:0];
    w_quot    = (w_x_neg ^ w_y_neg) ? -w_q_nxt : w_q_nxt;
    w_rem     = w_x_neg ? -w_rem_mag : w_rem_mag;
    if (r_y == '0) begin
      w_quot = '1;
      w_rem  = r_x;
    end
  end

  // Operand capture, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_op  <= OP_NOP;
      r_x   <= '0;
      r_y   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
      obus  <= '0;
      fin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          obus <= '0;
          fin  <= 1'b0;
          if (w_op_valid) begin
            r_op <= op_e'(opcode);
            r_x  <= ibus;
          end
        end
        S_LOAD_Y: begin
          r_y   <= ibus;
          r_acc <= '0;
          r_qm1 <= 1'b0;
          r_cnt <= '0;
          r_q   <= (r_op == OP_MUL) ? r_x : w_x_mag;
        end
        S_EXEC: begin
          obus <= w_exec;
          fin  <= 1'b1;
        end
        S_ITER: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            fin <= 1'b1;
            if (r_op == OP_MUL) begin
              obus <= w_q_nxt;
            end else begin
              obus  <= w_quot;
              r_acc <= {2'b00, w_rem};
            end
          end
        end
        S_OUT1: obus <= r_acc[WIDTH-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, randomized ops against an
// arithmetic reference model, back-to-back, opcode change and reset cases.
module tb_alu;

  localparam logic [3:0] C_NOP = 4'b0000;
  localparam logic [3:0] C_ADD = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_SHR = 4'b0101;
  localparam logic [3:0] C_SHL = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0111;
  localparam logic [3:0] C_OR  = 4'b1000;
  localparam logic [3:0] C_NEG = 4'b1001;
  localparam logic [3:0] C_MUL = 4'b1010;
  localparam logic [3:0] C_DIV = 4'b1011;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [3:0]  opcode;
  logic [31:0] ibus;
  logic [31:0] obus;
  logic        fin;

  int checks   = 0;
  int failures = 0;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .opcode (opcode),
    .ibus   (ibus),
    .obus   (obus),
    .fin    (fin)
  );

  always #5 clk = ~clk;

  // Reference model: plain signed arithmetic on 64-bit integers
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] w0, output logic [31:0] w1, output int nw);
    longint sx, sy, p, q, r;
    logic [63:0] pv;
    logic [4:0]  sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    w0 = '0;
    w1 = '0;
    nw = 1;
    case (op)
      C_ADD: w0 = 32'(sx + sy);
      C_SUB: w0 = 32'(sx - sy);
      C_AND: w0 = x & y;
      C_OR:  w0 = x | y;
      C_NEG: w0 = 32'(0 - sx);
      C_SHL: w0 = 32'(sx * (longint'(1) << sh));
      C_SHR: begin
        p = longint'(1) << sh;
        q = sx / p;
        if ((sx % p != 0) && (sx < 0)) q = q - 1;
        w0 = 32'(q);
      end
      C_MUL: begin
        pv = 64'(sx * sy);
        w0 = pv[31:0];
        w1 = pv[63:32];
        nw = 2;
      end
      C_DIV: begin
        nw = 2;
        if (sy == 0) begin
          w0 = '1;
          w1 = x;
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          w0 = 32'(q);
          w1 = 32'(r);
        end
      end
      default: nw = 0;
    endcase
  endfunction

  // Drive one operation and collect its result words; no checking here
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int chg_at,
                        output logic [31:0] w0, output logic [31:0] w1,
                        output int lat, output int flen, output logic [31:0] obus_after);
    w0 = '0;
    w1 = '0;
    lat = -1;
    flen = 0;
    obus_after = '1;
    @(negedge clk);
    opcode = op;
    ibus   = x;
    @(negedge clk);
    opcode = C_NOP;
    ibus   = y;
    @(negedge clk);
    ibus   = $urandom();
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (fin === 1'b1) begin
        lat = n;
        break;
      end
      if (n == chg_at) opcode = C_AND;
      if (n == chg_at + 8) opcode = C_NOP;
    end
    if (lat > 0) begin
      w0 = obus;
      flen = 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (fin === 1'b1) begin
          flen++;
          if (flen == 2) w1 = obus;
        end else begin
          obus_after = obus;
          break;
        end
      end
    end
    opcode = C_NOP;
  endtask

  task automatic test_reset();
    opcode = C_NOP;
    ibus   = '0;
    rst_b  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (fin !== 1'b0) begin
      failures++;
      $display("FAIL reset_fin: got %b expected 0", fin);
    end
    checks++;
    if (obus !== 32'h0) begin
      failures++;
      $display("FAIL reset_obus: got %h expected 00000000", obus);
    end
    rst_b = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e0;
    logic [31:0] e1;
    int          nw;
  } vec_t;

  task automatic test_directed();
    vec_t vt[14];
    logic [31:0] w0, w1, oa;
    int lat, flen;
    vt[0]  = '{C_ADD, 32'hFFFFFF9B, 32'd3, 32'hFFFFFF9E, 32'h0, 1};
    vt[1]  = '{C_SUB, 32'hFFFFFF9B, 32'd3, 32'hFFFFFF98, 32'h0, 1};
    vt[2]  = '{C_AND, 32'hFFFFFF9B, 32'd3, 32'h00000003, 32'h0, 1};
    vt[3]  = '{C_OR,  32'hFFFFFF9B, 32'd3, 32'hFFFFFF9B, 32'h0, 1};
    vt[4]  = '{C_NEG, 32'hFFFFFF9B, 32'd3, 32'h00000065, 32'h0, 1};
    vt[5]  = '{C_SHL, 32'hFFFFFF9B, 32'd3, 32'hFFFFFCD8, 32'h0, 1};
    vt[6]  = '{C_SHR, 32'hFFFFFF9B, 32'd3, 32'hFFFFFFF3, 32'h0, 1};
    vt[7]  = '{C_MUL, 32'hFFFFFF9B, 32'd3, 32'hFFFFFED1, 32'hFFFFFFFF, 2};
    vt[8]  = '{C_DIV, 32'hFFFFFF9B, 32'd3, 32'hFFFFFFDF, 32'hFFFFFFFE, 2};
    vt[9]  = '{C_MUL, 32'd101, 32'd63, 32'h000018DB, 32'h00000000, 2};
    vt[10] = '{C_DIV, 32'd101, 32'd63, 32'h00000001, 32'h00000026, 2};
    vt[11] = '{C_DIV, 32'hFFFFFF9B, 32'hFFFFFFC1, 32'h00000001, 32'hFFFFFFDA, 2};
    vt[12] = '{C_DIV, 32'hFFFFFF9B, 32'h0, 32'hFFFFFFFF, 32'hFFFFFF9B, 2};
    vt[13] = '{C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 2};
    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].op, vt[i].x, vt[i].y, 0, w0, w1, lat, flen, oa);
      checks++;
      if (lat != ((vt[i].nw == 2) ? 32 : 1)) begin
        failures++;
        $display("FAIL dir%0d_latency op=%h: got %0d expected %0d", i, vt[i].op, lat,
                 (vt[i].nw == 2) ? 32 : 1);
      end
      checks++;
      if (flen != vt[i].nw) begin
        failures++;
        $display("FAIL dir%0d_fin_len op=%h: got %0d expected %0d", i, vt[i].op, flen, vt[i].nw);
      end
      checks++;
      if (w0 !== vt[i].e0) begin
        failures++;
        $display("FAIL dir%0d_word0 op=%h: got %h expected %h", i, vt[i].op, w0, vt[i].e0);
      end
      if (vt[i].nw == 2) begin
        checks++;
        if (w1 !== vt[i].e1) begin
          failures++;
          $display("FAIL dir%0d_word1 op=%h: got %h expected %h", i, vt[i].op, w1, vt[i].e1);
        end
      end
      checks++;
      if (oa !== 32'h0) begin
        failures++;
        $display("FAIL dir%0d_obus_idle op=%h: got %h expected 00000000", i, vt[i].op, oa);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h0;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    logic [3:0]  ops[9];
    logic [3:0]  op;
    logic [31:0] x, y, w0, w1, e0, e1, oa;
    int lat, flen, nw;
    ops = '{C_ADD, C_SUB, C_SHR, C_SHL, C_AND, C_OR, C_NEG, C_MUL, C_DIV};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      x  = pick_operand();
      y  = pick_operand();
      model(op, x, y, e0, e1, nw);
      run_op(op, x, y, 0, w0, w1, lat, flen, oa);
      checks++;
      if (lat != ((nw == 2) ? 32 : 1) || flen != nw) begin
        failures++;
        $display("FAIL rnd%0d_timing op=%h: got lat=%0d fin_len=%0d expected lat=%0d fin_len=%0d",
                 i, op, lat, flen, (nw == 2) ? 32 : 1, nw);
      end
      checks++;
      if (w0 !== e0) begin
        failures++;
        $display("FAIL rnd%0d_word0 op=%h x=%h y=%h: got %h expected %h", i, op, x, y, w0, e0);
      end
      if (nw == 2) begin
        checks++;
        if (w1 !== e1) begin
          failures++;
          $display("FAIL rnd%0d_word1 op=%h x=%h y=%h: got %h expected %h", i, op, x, y, w1, e1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs[5], ys[5];
    logic [31:0] exp_sum;
    for (int i = 0; i < 5; i++) begin
      xs[i] = $urandom();
      ys[i] = $urandom();
    end
    @(negedge clk);
    opcode = C_ADD;
    ibus   = xs[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (fin !== 1'b0) begin
        failures++;
        $display("FAIL b2b%0d_fin_after_x: got %b expected 0", i, fin);
      end
      ibus = ys[i];
      @(negedge clk);
      checks++;
      if (fin !== 1'b0) begin
        failures++;
        $display("FAIL b2b%0d_fin_after_y: got %b expected 0", i, fin);
      end
      @(negedge clk);
      exp_sum = xs[i] + ys[i];
      checks++;
      if (fin !== 1'b1 || obus !== exp_sum) begin
        failures++;
        $display("FAIL b2b%0d_result: got fin=%b obus=%h expected fin=1 obus=%h", i, fin, obus, exp_sum);
      end
      ibus = xs[i+1];
      if (i == 3) opcode = C_NOP;
    end
    @(negedge clk);
    checks++;
    if (fin !== 1'b0 || obus !== 32'h0) begin
      failures++;
      $display("FAIL b2b_end: got fin=%b obus=%h expected fin=0 obus=00000000", fin, obus);
    end
  endtask

  task automatic test_opcode_change();
    logic [31:0] x, y, w0, w1, e0, e1, oa;
    int lat, flen, nw;
    x = $urandom();
    y = $urandom();
    model(C_MUL, x, y, e0, e1, nw);
    run_op(C_MUL, x, y, 5, w0, w1, lat, flen, oa);
    checks++;
    if (lat != 32 || flen != 2 || w0 !== e0 || w1 !== e1) begin
      failures++;
      $display("FAIL opchg_mul: got lat=%0d len=%0d %h:%h expected lat=32 len=2 %h:%h",
               lat, flen, w1, w0, e1, e0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fin !== 1'b0) begin
      failures++;
      $display("FAIL opchg_idle_fin: got %b expected 0", fin);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] w0, w1, oa;
    int lat, flen, highs;
    @(negedge clk);
    opcode = C_MUL;
    ibus   = 32'h12345678;
    @(negedge clk);
    opcode = C_NOP;
    ibus   = 32'hFEDCBA98;
    repeat (11) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (fin !== 1'b0 || obus !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: got fin=%b obus=%h expected fin=0 obus=00000000", fin, obus);
    end
    rst_b = 1'b0;
    highs = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (fin === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL rstmid_abandoned: got %0d fin cycles expected 0", highs);
    end
    run_op(C_ADD, 32'd5, 32'd7, 0, w0, w1, lat, flen, oa);
    checks++;
    if (w0 !== 32'd12 || flen != 1 || lat != 1) begin
      failures++;
      $display("FAIL rstmid_add: got obus=%h len=%0d lat=%0d expected obus=0000000c len=1 lat=1",
               w0, flen, lat);
    end
  endtask

  task automatic test_invalid_opcode();
    logic [3:0] bad[6];
    int highs;
    bad = '{4'b0001, 4'b0010, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      opcode = bad[i];
      ibus   = $urandom();
      if (fin === 1'b1) highs++;
    end
    opcode = C_NOP;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (fin === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL invalid_op_fin: got %0d fin cycles expected 0", highs);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_opcode_change();
    test_reset_mid_op();
    test_invalid_opcode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit sequential ALU with a two-word operand bus protocol. It sits between a shared input bus and a shared output bus. A non-NOP opcode starts an operation: operand X is captured from `ibus`, then operand Y on the next cycle. The block computes the result and drives it on `obus` while pulsing `fin`. ADD/SUB/logic/shift/NEG finish in one compute cycle; MUL and DIV are iterative and return two result words.

## Interface
- `WIDTH`, 32, operand/bus width; all behaviour below is specified for 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_b`  in  1  reset, synchronous and active-high (asserted = 1, despite the name).
- `opcode`  in  4  operation select (type `op_e`).
  - 0000 NOP
  - 0011 ADD
  - 0100 SUB
  - 0101 SHR
  - 0110 SHL
  - 0111 AND
  - 1000 OR
  - 1001 NEG
  - 1010 MUL
  - 1011 DIV
  - All other codes are treated as NOP.
- `ibus`  in  WIDTH  operand input bus.
- `obus`  out  WIDTH  result bus, registered.
- `fin`  out  1  result-valid strobe, registered.

## Operation
- States:
  - IDLE → LOAD_Y → EXEC, for single-cycle ops.
  - IDLE → LOAD_Y → ITER(×32) → OUT1, for MUL/DIV.
- IDLE:
  - `fin`=0, `obus`=0.
  - If `opcode` is not NOP at an edge, latch `opcode` and capture `ibus` into X, then go to LOAD_Y.
- LOAD_Y: capture `ibus` into Y.
  - Go to EXEC for single-cycle ops, or to ITER with the step counter at 0 for MUL/DIV.
- Opcode latching: the opcode is latched at the X capture. Changes to `opcode` during an operation are ignored.
- EXEC computes the result; the register update is `obus`←result, `fin`←1, then go to IDLE.
- Single-cycle ops (all two's complement, results truncated to 32 bits, no flags, overflow wraps):
  - ADD: X+Y
  - SUB: X−Y
  - AND: X&Y
  - OR: X|Y
  - NEG: −X (Y is captured but ignored)
  - SHL: X<<Y[4:0], zero fill
  - SHR: arithmetic shift of X right by Y[4:0], sign fill
- MUL: signed 32×32→64 (radix-2 Booth, one step per ITER cycle).
- DIV: signed non-restoring division, one step per ITER cycle.
  - The last ITER edge applies the restore/sign correction.
  - Quotient truncates toward zero; the remainder takes the sign of X.
  - Y=0: quotient = 0xFFFFFFFF, remainder = X.
- ITER, final edge:
  - MUL: `obus`←low word, `fin`←1.
  - DIV: `obus`←quotient, `fin`←1.
  - Then go to OUT1.
- OUT1:
  - MUL: `obus`←high word, `fin` stays 1.
  - DIV: `obus`←remainder, `fin` stays 1.
  - Then go to IDLE.
- Back-to-back operations: IDLE drops `fin` and may capture a new X in the same edge.
- Reset (any state, including mid-operation):
  - state←IDLE, `obus`←0, `fin`←0.
  - X, Y, accumulators and counter ← 0.
  - The operation in progress is abandoned.

## Timing
- Let E0 be the edge capturing X and E1 the edge capturing Y. Edges below are edge numbers (E2 is the edge after E1).
- Single-cycle ops:
  - `fin` rises at E2 and falls at E3.
  - Latency from X capture to result visible: 2 cycles.
- MUL/DIV:
  - ITER occupies edges E2..E33.
  - At E33, word0 is driven and `fin`=1.
  - At E34, word1 is driven and `fin`=1.
  - At E35, `fin`=0 and `obus`=0.
- `fin` high lengths: exactly 1 cycle for single-cycle ops, exactly 2 cycles for MUL/DIV.
- The environment must hold X on `ibus` across E0 and Y across E1. The block samples nothing else from `ibus`.
- The next operation may start at the edge where `fin` falls.

## Test plan
- Reset asserted mid-MUL (e.g. during ITER) → next cycle `fin`=0, `obus`=0; then ADD X=5, Y=7 → `obus`=12 with 1-cycle `fin`.
- X=0xFFFFFF9B (−101), Y=3, single-cycle ops, each must give a 1-cycle `fin` pulse:
  - ADD → 0xFFFFFF9E
  - SUB → 0xFFFFFF98
  - AND → 0x00000003
  - OR → 0xFFFFFF9B
  - NEG → 0x00000065
  - SHL → 0xFFFFFCD8
  - SHR → 0xFFFFFFF3
- Same operands, MUL → 0xFFFFFED1 then 0xFFFFFFFF on two consecutive `fin` cycles.
- Same operands, DIV → 0xFFFFFFDF then 0xFFFFFFFE.
- X=101, Y=63:
  - MUL → 0x000018DB then 0x00000000.
  - DIV → 0x00000001 then 0x00000026.
- X=−101, Y=−63:
  - DIV → 1 then 0xFFFFFFDA.
  - Divide-by-zero (DIV with X=−101, Y=0) → 0xFFFFFFFF then X.
- Back-to-back: hold `opcode` at ADD continuously → a new operation captures X at each `fin`-falling edge.
- Opcode change mid-operation: change `opcode` from MUL to AND during ITER → the MUL result is still produced unchanged.
